// File: rtl/bf2_span4_stage.sv
// Span-4 radix-2 butterfly stage with the frame beat counter that drives the
// next multiplier's twiddle select. Optional output register: BF2_SPAN4_OUT_PIPE_EN.
module bf2_span4_stage #(
  parameter int I_WIDTH     = 14,
  parameter int O_WIDTH     = 15,
  parameter int DATA_WIDTH  = 16,
  parameter int SPAN        = 4,
  parameter int FRAME_BEATS = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      din_valid,
  input  logic                      din_sop,
  input  logic signed [I_WIDTH-1:0] din_re [0:DATA_WIDTH-1],
  input  logic signed [I_WIDTH-1:0] din_im [0:DATA_WIDTH-1],
  output logic                      dout_valid,
  output logic                      dout_sop,
  output logic signed [O_WIDTH-1:0] dout_re [0:DATA_WIDTH-1],
  output logic signed [O_WIDTH-1:0] dout_im [0:DATA_WIDTH-1],
  output logic [1:0]                sel_out,
  output logic                      frame_err
);

  // Handshake: din_valid alone qualifies a beat (no ready). Every valid beat is
  // consumed on the edge it is sampled and appears exactly once with dout_valid.

  localparam int GROUPS = DATA_WIDTH / (2 * SPAN);
  localparam int CW     = (FRAME_BEATS > 4) ? $clog2(FRAME_BEATS) : 2;
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_BEATS - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] bidx;
  logic [CW-1:0] cnt_nxt;
  logic          err_nxt;

  logic signed [O_WIDTH-1:0] bf_re [0:DATA_WIDTH-1];
  logic signed [O_WIDTH-1:0] bf_im [0:DATA_WIDTH-1];

  logic                      s1_valid;
  logic                      s1_sop;
  logic [1:0]                s1_sel;
  logic                      s1_err;
  logic signed [O_WIDTH-1:0] s1_re [0:DATA_WIDTH-1];
  logic signed [O_WIDTH-1:0] s1_im [0:DATA_WIDTH-1];

  // A sop always restarts the frame; a counter at 0 without sop is a silent wrap.
  always_comb begin
    bidx    = din_sop ? '0 : cnt;
    cnt_nxt = (bidx == LAST_BEAT) ? '0 : bidx + CW'(1);
    err_nxt = din_valid & din_sop & (cnt != '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (din_valid) begin
      cnt <= cnt_nxt;
    end
  end

  // Sign extension before add/sub gives the full 1-bit growth, so no wrap.
  always_comb begin
    bf_re = '{default: '0};
    bf_im = '{default: '0};
    for (int g = 0; g < GROUPS; g++) begin
      for (int k = 0; k < SPAN; k++) begin
        bf_re[g*2*SPAN+k]      = O_WIDTH'(din_re[g*2*SPAN+k]) + O_WIDTH'(din_re[g*2*SPAN+k+SPAN]);
        bf_re[g*2*SPAN+k+SPAN] = O_WIDTH'(din_re[g*2*SPAN+k]) - O_WIDTH'(din_re[g*2*SPAN+k+SPAN]);
        bf_im[g*2*SPAN+k]      = O_WIDTH'(din_im[g*2*SPAN+k]) + O_WIDTH'(din_im[g*2*SPAN+k+SPAN]);
        bf_im[g*2*SPAN+k+SPAN] = O_WIDTH'(din_im[g*2*SPAN+k]) - O_WIDTH'(din_im[g*2*SPAN+k+SPAN]);
      end
    end
  end

  // Data and select hold across idle cycles; sop and err are per-cycle pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_sel   <= 2'd0;
      s1_err   <= 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        s1_re[i] <= '0;
        s1_im[i] <= '0;
      end
    end else begin
      s1_valid <= din_valid;
      s1_sop   <= din_valid & din_sop;
      s1_err   <= err_nxt;
      if (din_valid) begin
        s1_sel <= bidx[1:0];
        for (int i = 0; i < DATA_WIDTH; i++) begin
          s1_re[i] <= bf_re[i];
          s1_im[i] <= bf_im[i];
        end
      end
    end
  end

`ifdef BF2_SPAN4_OUT_PIPE_EN
  logic                      s2_valid;
  logic                      s2_sop;
  logic [1:0]                s2_sel;
  logic                      s2_err;
  logic signed [O_WIDTH-1:0] s2_re [0:DATA_WIDTH-1];
  logic signed [O_WIDTH-1:0] s2_im [0:DATA_WIDTH-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_sop   <= 1'b0;
      s2_sel   <= 2'd0;
      s2_err   <= 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        s2_re[i] <= '0;
        s2_im[i] <= '0;
      end
    end else begin
      s2_valid <= s1_valid;
      s2_sop   <= s1_sop;
      s2_err   <= s1_err;
      if (s1_valid) begin
        s2_sel <= s1_sel;
        for (int i = 0; i < DATA_WIDTH; i++) begin
          s2_re[i] <= s1_re[i];
          s2_im[i] <= s1_im[i];
        end
      end
    end
  end

  assign dout_valid = s2_valid;
  assign dout_sop   = s2_sop;
  assign sel_out    = s2_sel;
  assign frame_err  = s2_err;
  assign dout_re    = s2_re;
  assign dout_im    = s2_im;
`else
  assign dout_valid = s1_valid;
  assign dout_sop   = s1_sop;
  assign sel_out    = s1_sel;
  assign frame_err  = s1_err;
  assign dout_re    = s1_re;
  assign dout_im    = s1_im;
`endif

endmodule

// File: tb/tb_bf2_span4_stage.sv
// Self-checking bench for bf2_span4_stage: scoreboard of expected beats plus
// per-scenario directed checks; follows BF2_SPAN4_OUT_PIPE_EN for latency.
module tb_bf2_span4_stage;

  localparam int IW = 14;
  localparam int OW = 15;
  localparam int NS = 16;
  localparam int FB = 32;
`ifdef BF2_SPAN4_OUT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int PW = 2 * NS * OW;
  localparam int EW = PW + 4;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic                 din_valid;
  logic                 din_sop;
  logic signed [IW-1:0] din_re [0:NS-1];
  logic signed [IW-1:0] din_im [0:NS-1];
  logic                 dout_valid;
  logic                 dout_sop;
  logic signed [OW-1:0] dout_re [0:NS-1];
  logic signed [OW-1:0] dout_im [0:NS-1];
  logic [1:0]           sel_out;
  logic                 frame_err;

  bf2_span4_stage #(
    .I_WIDTH(IW), .O_WIDTH(OW), .DATA_WIDTH(NS), .SPAN(4), .FRAME_BEATS(FB)
  ) dut (
    .clk(clk), .rstn(rstn),
    .din_valid(din_valid), .din_sop(din_sop),
    .din_re(din_re), .din_im(din_im),
    .dout_valid(dout_valid), .dout_sop(dout_sop),
    .dout_re(dout_re), .dout_im(dout_im),
    .sel_out(sel_out), .frame_err(frame_err)
  );

  // ---------------- scoreboard state ----------------
  int             n_cmp = 0;
  int             n_err = 0;
  int             model_cnt = 0;
  logic [EW-1:0]  exp_q[$];
  logic [EW-1:0]  exp_v;
  logic [EW-1:0]  act_v;
  logic [PW-1:0]  last_data = '0;

  function automatic logic [PW-1:0] pack_out();
    logic [PW-1:0] v;
    for (int i = 0; i < NS; i++) begin
      v[i*OW +: OW]        = dout_re[i];
      v[PW/2 + i*OW +: OW] = dout_im[i];
    end
    return v;
  endfunction

  // Reference butterfly: lanes g*8+k and g*8+k+4, sum then difference.
  function automatic logic [PW-1:0] model_bfly();
    logic [PW-1:0]        v;
    logic signed [OW-1:0] a;
    logic signed [OW-1:0] b;
    int                   lo;
    int                   hi;
    v = '0;
    for (int g = 0; g < NS / 8; g++) begin
      for (int k = 0; k < 4; k++) begin
        lo = g * 8 + k;
        hi = lo + 4;
        a = din_re[lo];
        b = din_re[hi];
        v[lo*OW +: OW] = a + b;
        v[hi*OW +: OW] = a - b;
        a = din_im[lo];
        b = din_im[hi];
        v[PW/2 + lo*OW +: OW] = a + b;
        v[PW/2 + hi*OW +: OW] = a - b;
      end
    end
    return v;
  endfunction

  task automatic push_expected(input bit sop);
    int bidx;
    bit err;
    bidx = sop ? 0 : model_cnt;
    err  = sop && (model_cnt != 0);
    model_cnt = (bidx == FB - 1) ? 0 : bidx + 1;
    exp_q.push_back({err, sop, 2'(bidx), model_bfly()});
  endtask

  // Output monitor: pops one expectation per valid beat, checks holds when idle.
  always @(posedge clk) begin
    #2;
    if (rstn) begin
      if (dout_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: dout_valid=1 with no expected beat at %0t", $time);
        end else begin
          exp_v = exp_q.pop_front();
          act_v = {frame_err, dout_sop, sel_out, pack_out()};
          if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL beat: got err=%0b sop=%0b sel=%0d data=%h, want err=%0b sop=%0b sel=%0d data=%h",
                     act_v[EW-1], act_v[EW-2], act_v[EW-3:EW-4], act_v[PW-1:0],
                     exp_v[EW-1], exp_v[EW-2], exp_v[EW-3:EW-4], exp_v[PW-1:0]);
          end
        end
        last_data = pack_out();
      end else begin
        n_cmp++;
        if (dout_sop !== 1'b0 || frame_err !== 1'b0 || pack_out() !== last_data) begin
          n_err++;
          $display("FAIL idle_hold: got sop=%0b err=%0b data=%h, want sop=0 err=0 data=%h",
                   dout_sop, frame_err, pack_out(), last_data);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rand_data();
    for (int i = 0; i < NS; i++) begin
      din_re[i] = IW'($urandom);
      din_im[i] = IW'($urandom);
    end
  endtask

  task automatic drive(input bit v, input bit sop);
    din_valid = v;
    din_sop   = sop;
    if (v) push_expected(sop);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_sop   = 1'b0;
  endtask

  task automatic wait_latency();
    for (int c = 2; c <= LAT; c++) drive(1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({dout_valid, dout_sop, sel_out, frame_err} !== 5'b0 || pack_out() !== '0) begin
      n_err++;
      $display("FAIL %s: got valid=%0b sop=%0b sel=%0d err=%0b data=%h, want all 0",
               name, dout_valid, dout_sop, sel_out, frame_err, pack_out());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) begin
      rand_data();
      din_valid = 1'($urandom_range(0, 1));
      din_sop   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    check_all_zero("reset_state");
    exp_q.delete();
    model_cnt = 0;
    last_data = '0;
    din_valid = 1'b0;
    din_sop   = 1'b0;
    rstn = 1'b1;
    drive(1'b0, 1'b0);
  endtask

  task automatic test_first_beat();
    for (int i = 0; i < NS; i++) begin
      din_re[i] = IW'(i);
      din_im[i] = '0;
    end
    drive(1'b1, 1'b1);
    for (int c = 1; c <= LAT; c++) begin
      if (c > 1) drive(1'b0, 1'b0);
      n_cmp++;
      if (dout_valid !== 1'(c == LAT)) begin
        n_err++;
        $display("FAIL latency: cycle %0d got dout_valid=%0b, want %0b", c, dout_valid, c == LAT);
      end
    end
    n_cmp++;
    if (dout_re[0] !== 4 || dout_re[4] !== -4) begin
      n_err++;
      $display("FAIL first_beat_g0: got out0=%0d out4=%0d, want 4 -4", dout_re[0], dout_re[4]);
    end
    n_cmp++;
    if (dout_re[8] !== 20 || dout_re[12] !== -4) begin
      n_err++;
      $display("FAIL first_beat_g1: got out8=%0d out12=%0d, want 20 -4", dout_re[8], dout_re[12]);
    end
    n_cmp++;
    if (dout_sop !== 1'b1 || sel_out !== 2'd0 || frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL first_beat_ctl: got sop=%0b sel=%0d err=%0b, want 1 0 0", dout_sop, sel_out, frame_err);
    end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < NS; i++) begin
      din_re[i] = '0;
      din_im[i] = '0;
    end
    din_re[0] = -14'sd8192; din_re[4] = -14'sd8192;
    din_re[1] = 14'sd8191;  din_re[5] = -14'sd8192;
    din_im[2] = 14'sd8191;  din_im[6] = 14'sd8191;
    din_im[3] = -14'sd8192; din_im[7] = 14'sd8191;
    drive(1'b1, 1'b0);
    wait_latency();
    n_cmp++;
    if (dout_re[0] !== -16384 || dout_re[4] !== 0) begin
      n_err++;
      $display("FAIL extreme_neg: got sum=%0d diff=%0d, want -16384 0", dout_re[0], dout_re[4]);
    end
    n_cmp++;
    if (dout_re[1] !== -1 || dout_re[5] !== 16383) begin
      n_err++;
      $display("FAIL extreme_mix: got sum=%0d diff=%0d, want -1 16383", dout_re[1], dout_re[5]);
    end
    n_cmp++;
    if (dout_im[2] !== 16382 || dout_im[6] !== 0 || dout_im[3] !== -1 || dout_im[7] !== -16383) begin
      n_err++;
      $display("FAIL extreme_im: got %0d %0d %0d %0d, want 16382 0 -1 -16383",
               dout_im[2], dout_im[6], dout_im[3], dout_im[7]);
    end
  endtask

  task automatic test_frame_gaps();
    for (int b = 0; b < FB; b++) begin
      if (b == 5 || b == 17) begin
        repeat (3) drive(1'b0, 1'b0);
        n_cmp++;
        if (dout_valid !== 1'b0) begin
          n_err++;
          $display("FAIL gap_valid: beat %0d got dout_valid=%0b, want 0", b, dout_valid);
        end
      end
      rand_data();
      drive(1'b1, b == 0);
    end
    rand_data();
    drive(1'b1, 1'b0);
    wait_latency();
    n_cmp++;
    if ({dout_valid, dout_sop, sel_out, frame_err} !== 5'b1_0_00_0) begin
      n_err++;
      $display("FAIL frame_wrap: got valid=%0b sop=%0b sel=%0d err=%0b, want 1 0 0 0",
               dout_valid, dout_sop, sel_out, frame_err);
    end
  endtask

  task automatic test_mid_sop();
    for (int b = 0; b < 10; b++) begin
      rand_data();
      drive(1'b1, b == 0);
    end
    rand_data();
    drive(1'b1, 1'b1);
    wait_latency();
    n_cmp++;
    if ({frame_err, dout_sop, sel_out} !== 4'b1_1_00) begin
      n_err++;
      $display("FAIL mid_sop: got err=%0b sop=%0b sel=%0d, want 1 1 0", frame_err, dout_sop, sel_out);
    end
    drive(1'b0, 1'b0);
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_pulse_width: got frame_err=%0b one cycle later, want 0", frame_err);
    end
    for (int b = 1; b < 7; b++) begin
      rand_data();
      drive(1'b1, 1'b0);
    end
  endtask

  task automatic test_sop_at_last();
    for (int b = 0; b < FB - 1; b++) begin
      rand_data();
      drive(1'b1, b == 0);
    end
    rand_data();
    drive(1'b1, 1'b1);
    wait_latency();
    n_cmp++;
    if ({frame_err, dout_sop, sel_out} !== 4'b1_1_00) begin
      n_err++;
      $display("FAIL sop_at_last: got err=%0b sop=%0b sel=%0d, want 1 1 0", frame_err, dout_sop, sel_out);
    end
    repeat (3) begin
      rand_data();
      drive(1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    for (int b = 0; b < 7; b++) begin
      rand_data();
      drive(1'b1, b == 0);
    end
    rand_data();
    din_valid = 1'b1;
    din_sop   = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    model_cnt = 0;
    last_data = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    rstn = 1'b1;
    rand_data();
    drive(1'b1, 1'b0);
    wait_latency();
    n_cmp++;
    if ({dout_valid, dout_sop, sel_out, frame_err} !== 5'b1_0_00_0) begin
      n_err++;
      $display("FAIL post_reset_beat: got valid=%0b sop=%0b sel=%0d err=%0b, want 1 0 0 0",
               dout_valid, dout_sop, sel_out, frame_err);
    end
  endtask

  task automatic test_back_to_back();
    bit v;
    bit sop;
    for (int n = 0; n < 80; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      sop = v && ($urandom_range(0, 15) == 0);
      rand_data();
      drive(v, sop);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    din_valid = 1'b0;
    din_sop   = 1'b0;
    for (int i = 0; i < NS; i++) begin
      din_re[i] = '0;
      din_im[i] = '0;
    end
    #1;
    test_reset();
    test_first_beat();
    test_extremes();
    test_frame_gaps();
    test_mid_sop();
    test_sop_at_last();
    test_reset_mid();
    test_back_to_back();
    repeat (LAT + 2) drive(1'b0, 1'b0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d beats still expected, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
